trng_word_server: RTL and testbench

Responder end of the TRNG request/ready handshake. It turns a raw, possibly biased entropy bit stream from the FPGA sampler into debiased 32-bit words and buffers them in a small FIFO. It serves one word per request to any registered requester that raises `trng_request` while `ready` is low. A continuous repetition-count health test latches a sticky failure and stops service.

---
 rtl/trng_pkg.sv | 16 +
 rtl/trng_word_fifo.sv | 60 ++++++
 rtl/trng_word_server.sv | 151 +++++++++++++++
 tb/tb_trng_word_server.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG word server.
// Delivery FSM states, word width and default health/warmup settings.
package trng_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELIVER,
      ST_GAP,
      ST_FAIL
   } trng_state_e;

   localparam int unsigned TRNG_WORD_W      = 32;
   localparam int unsigned DEF_RCT_CUTOFF   = 32;
   localparam int unsigned DEF_WARMUP_WORDS = 1;

endpackage

// File: rtl/trng_word_fifo.sv
// First-word-fall-through word FIFO with flush; a push while full is
// accepted only when a pop frees a slot in the same cycle.
module trng_word_fifo
   import trng_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = TRNG_WORD_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [W-1:0]               i_din,
   output logic [W-1:0]               o_dout,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH+1)-1:0] o_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
         else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
      end
   end

   // Storage carries no reset; occupancy and pointers define validity.
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

// File: rtl/trng_word_server.sv
// TRNG responder: von Neumann debiasing, 32-bit word assembly with warmup
// discard, repetition-count health test and request/ready delivery FSM.
module trng_word_server
   import trng_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned RCT_CUTOFF   = DEF_RCT_CUTOFF,
   parameter int unsigned WARMUP_WORDS = DEF_WARMUP_WORDS
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            entropy_bit,
   input  logic                            entropy_valid,
   input  logic                            trng_request,
   output logic [TRNG_WORD_W-1:0]          random_number,
   output logic                            ready,
   output logic                            health_fail,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] words_available
);

   localparam int unsigned RCT_W = $clog2(RCT_CUTOFF + 1);

   trng_state_e             r_state;
   logic                    r_ready;
   logic [TRNG_WORD_W-1:0]  r_random;
   logic                    r_pair_have;
   logic                    r_pair_first;
   logic [TRNG_WORD_W-1:0]  r_word;
   logic [4:0]              r_bit_cnt;
   logic                    r_word_done;
   logic [15:0]             r_warmup;
   logic                    r_prev_bit;
   logic [RCT_W-1:0]        r_run_cnt;
   logic                    r_health_fail;

   logic [RCT_W-1:0]        w_run_next;
   logic                    w_trip;
   logic                    w_fail_now;
   logic                    w_emit;
   logic                    w_push;
   logic                    w_pop;
   logic                    w_fifo_full;
   logic                    w_fifo_empty;
   logic [TRNG_WORD_W-1:0]  w_fifo_dout;

   assign random_number = r_random;
   assign ready         = r_ready;
   assign health_fail   = r_health_fail;

   always_comb begin
      w_run_next = r_run_cnt;
      w_trip     = 1'b0;
      if (entropy_valid) begin
         if (r_run_cnt == '0 || entropy_bit != r_prev_bit)
            w_run_next = RCT_W'(1);
         else if (r_run_cnt < RCT_W'(RCT_CUTOFF))
            w_run_next = r_run_cnt + RCT_W'(1);
         w_trip = !r_health_fail && (w_run_next >= RCT_W'(RCT_CUTOFF));
      end
   end

   // A trip on this edge already counts as failed: it blocks pop, push and emit.
   assign w_fail_now = w_trip || r_health_fail;
   assign w_emit     = entropy_valid && r_pair_have && (r_pair_first != entropy_bit) && !w_fail_now;
   assign w_pop      = (r_state == ST_IDLE) && trng_request && !w_fifo_empty && !w_fail_now;
   assign w_push     = r_word_done && (r_warmup == '0) && !w_fail_now && (!w_fifo_full || w_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_run_cnt     <= '0;
         r_prev_bit    <= 1'b0;
         r_health_fail <= 1'b0;
      end else if (entropy_valid) begin
         r_run_cnt  <= w_run_next;
         r_prev_bit <= entropy_bit;
         if (w_trip) r_health_fail <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pair_have  <= 1'b0;
         r_pair_first <= 1'b0;
         r_word       <= '0;
         r_bit_cnt    <= '0;
         r_word_done  <= 1'b0;
         r_warmup     <= 16'(WARMUP_WORDS);
      end else if (w_fail_now) begin
         r_pair_have  <= 1'b0;
         r_pair_first <= 1'b0;
         r_word       <= '0;
         r_bit_cnt    <= '0;
         r_word_done  <= 1'b0;
      end else begin
         r_word_done <= 1'b0;
         if (entropy_valid) begin
            r_pair_have <= !r_pair_have;
            if (!r_pair_have) r_pair_first <= entropy_bit;
         end
         if (w_emit) begin
            r_word    <= {r_word[TRNG_WORD_W-2:0], r_pair_first};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd31) r_word_done <= 1'b1;
         end
         if (r_word_done && r_warmup != '0) r_warmup <= r_warmup - 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_ready  <= 1'b0;
         r_random <= '0;
      end else if (w_fail_now) begin
         r_state  <= ST_FAIL;
         r_ready  <= 1'b0;
         r_random <= '0;
      end else begin
         r_ready <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_state  <= ST_DELIVER;
                  r_ready  <= 1'b1;
                  r_random <= w_fifo_dout;
               end
            end
            ST_DELIVER: r_state <= ST_GAP;
            ST_GAP:     r_state <= ST_IDLE;
            default:    r_state <= ST_FAIL;
         endcase
      end
   end

   trng_word_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (TRNG_WORD_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_flush (w_fail_now),
      .i_din   (r_word),
      .o_dout  (w_fifo_dout),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (words_available)
   );

endmodule

// File: tb/tb_trng_word_server.sv
// Scoreboard bench for trng_word_server: a cycle-stepped reference model
// queues expected words; a negedge monitor checks every ready pulse.
module tb_trng_word_server;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        entropy_bit = 1'b0;
   logic        entropy_valid = 1'b0;
   logic        trng_request = 1'b0;
   logic [31:0] random_number;
   logic        ready;
   logic        health_fail;
   logic [2:0]  words_available;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int t_ready[$];

   logic [31:0] exp_q[$];
   int          m_warm;
   int          m_run;
   bit          m_prev, m_fail, m_have, m_first, m_pend;
   int          m_nbits;
   logic [31:0] m_word, m_pend_word;

   trng_word_server #(
      .FIFO_DEPTH   (DEPTH),
      .RCT_CUTOFF   (32),
      .WARMUP_WORDS (1)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .entropy_bit     (entropy_bit),
      .entropy_valid   (entropy_valid),
      .trng_request    (trng_request),
      .random_number   (random_number),
      .ready           (ready),
      .health_fail     (health_fail),
      .words_available (words_available)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
   endtask

   always @(negedge clk) begin
      if (!rst && ready) begin
         t_ready.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_ready: got word 0x%08h expected no delivery (cycle %0d)", random_number, cyc);
         end else begin
            chk("delivered_word", random_number, exp_q.pop_front());
         end
      end
   end

   task automatic m_reset();
      exp_q.delete();
      m_warm = 1; m_run = 0; m_prev = 0; m_fail = 0;
      m_have = 0; m_first = 0; m_nbits = 0; m_word = '0; m_pend = 0;
   endtask

   // Reference behaviour of one clock edge given the raw input on that edge.
   task automatic m_edge(input logic v, input logic b);
      if (m_pend && !m_fail) begin
         if (m_warm > 0) m_warm--;
         else if (exp_q.size() < DEPTH) exp_q.push_back(m_pend_word);
      end
      m_pend = 0;
      if (v) begin
         m_run  = (m_run == 0 || b != m_prev) ? 1 : m_run + 1;
         m_prev = b;
         if (m_run >= 32 && !m_fail) begin
            m_fail = 1; exp_q.delete(); m_have = 0; m_nbits = 0;
         end else if (!m_fail) begin
            if (!m_have) begin
               m_have = 1; m_first = b;
            end else begin
               m_have = 0;
               if (m_first != b) begin
                  m_word = {m_word[30:0], m_first};
                  m_nbits++;
                  if (m_nbits == 32) begin
                     m_nbits = 0; m_pend = 1; m_pend_word = m_word;
                  end
               end
            end
         end
      end
   endtask

   task automatic tick(input logic v, input logic b, input logic req);
      entropy_valid = v; entropy_bit = b; trng_request = req;
      @(posedge clk);
      m_edge(v, b);
      #1;
      chk("health_fail", {31'd0, health_fail}, {31'd0, m_fail});
   endtask

   task automatic feed_pairs(input logic [1:0] p, input int n, input logic req);
      for (int i = 0; i < n; i++) begin
         tick(1'b1, p[1], req);
         tick(1'b1, p[0], req);
      end
   endtask

   task automatic feed_random_pairs(input int n);
      logic [1:0] p;
      for (int i = 0; i < n; i++) begin
         p = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
         feed_pairs(p, 1, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      for (int i = 0; i < 3 * DEPTH + 10; i++) tick(1'b0, 1'b0, 1'b1);
      idle(3);
      chk("drain_words_available", {29'd0, words_available}, 32'd0);
      chk("drain_undelivered", exp_q.size(), 32'd0);
   endtask

   task automatic do_reset();
      entropy_valid = 0; entropy_bit = 0; trng_request = 0;
      rst = 1'b1;
      m_reset();
      @(posedge clk); #1;
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_random_number", random_number, 32'd0);
      chk("rst_health_fail", {31'd0, health_fail}, 32'd0);
      chk("rst_words_available", {29'd0, words_available}, 32'd0);
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int tens;
      int r;
      int n;
      bit got;
      logic [1:0] p;

      // Alternating pairs with a live requester: warmup word dropped, one 0xAAAAAAAA delivered.
      do_reset();
      t_ready.delete();
      for (int i = 0; i < 32; i++) begin
         feed_pairs(2'b10, 1, 1'b1);
         feed_pairs(2'b01, 1, 1'b1);
      end
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1);
      chk("t1_ready_count", t_ready.size(), 32'd1);
      chk("t1_words_available", {29'd0, words_available}, 32'd0);
      drain();

      // Two buffered words, then a held request: pulses 3 cycles apart.
      do_reset();
      feed_pairs(2'b10, 32, 1'b0);
      feed_pairs(2'b10, 32, 1'b0);
      feed_pairs(2'b01, 32, 1'b0);
      idle(3);
      chk("t2_words_available", {29'd0, words_available}, 32'd2);
      t_ready.delete();
      tick(1'b0, 1'b0, 1'b1);
      t = cyc;
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b1);
      chk("t2_ready_count", t_ready.size(), 32'd2);
      if (t_ready.size() >= 2) begin
         chk("t2_first_latency", t_ready[0], t);
         chk("t2_pulse_spacing", t_ready[1], t + 3);
      end
      drain();

      // Five words into a depth-4 FIFO: occupancy saturates, four deliveries.
      do_reset();
      feed_pairs(2'b10, 32 * 6, 1'b0);
      idle(3);
      chk("t3_words_saturated", {29'd0, words_available}, 32'd4);
      t_ready.delete();
      drain();
      chk("t3_ready_count", t_ready.size(), 32'd4);

      // Health trip with buffered words: flush, zero output, no further service.
      do_reset();
      feed_random_pairs(32 * 3);
      idle(3);
      chk("t4_words_before_trip", {29'd0, words_available}, 32'd2);
      for (int i = 0; i < 32; i++) tick(1'b1, 1'b0, 1'b0);
      chk("t4_health_fail", {31'd0, health_fail}, 32'd1);
      chk("t4_words_flushed", {29'd0, words_available}, 32'd0);
      chk("t4_random_zero", random_number, 32'd0);
      t_ready.delete();
      for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 1'b1);
      feed_pairs(2'b10, 40, 1'b1);
      chk("t4_no_ready_after_fail", t_ready.size(), 32'd0);
      chk("t4_health_sticky", {31'd0, health_fail}, 32'd1);

      // Discard pairs 00/11 mixed with 10: a word needs exactly 32 pairs of 10.
      do_reset();
      tens = 0;
      while (tens < 63) begin
         r = $urandom_range(0, 2);
         p = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : 2'b10;
         if (p == 2'b10) tens++;
         feed_pairs(p, 1, 1'b0);
      end
      idle(3);
      chk("t5_words_before_last", {29'd0, words_available}, 32'd0);
      feed_pairs(2'b10, 1, 1'b0);
      idle(3);
      chk("t5_words_after_last", {29'd0, words_available}, 32'd1);
      drain();

      // Reset during DELIVER: outputs clear asynchronously, warmup restarts.
      do_reset();
      feed_random_pairs(32 * 3);
      idle(3);
      got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
         tick(1'b0, 1'b0, 1'b1);
         if (ready) got = 1;
      end
      chk("t6_ready_seen", {31'd0, got}, 32'd1);
      #1 rst = 1'b1;
      #1;
      chk("t6_async_ready", {31'd0, ready}, 32'd0);
      chk("t6_async_random", random_number, 32'd0);
      trng_request = 1'b0;
      m_reset();
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      t_ready.delete();
      feed_pairs(2'b10, 32, 1'b0);
      feed_random_pairs(32);
      idle(3);
      chk("t6_words_after_warmup", {29'd0, words_available}, 32'd1);
      drain();
      chk("t6_ready_count", t_ready.size(), 32'd1);

      // Biased random raw stream with gaps in entropy_valid.
      for (int it = 0; it < 4; it++) begin
         do_reset();
         n = $urandom_range(300, 1500);
         for (int i = 0; i < n; i++)
            tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, 1'b0);
         idle(3);
         chk("rand_words_available", {29'd0, words_available}, exp_q.size());
         drain();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
